// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect handshake between the pipeline stages and the pipeline controller.
// The controller binds to the master modport, and the pipeline datapath binds to the slave modport.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 64
);
  logic              ex_jump_req_i;
  logic [ADDR_W-1:0] ex_jump_addr_i;
  logic              id_load_use_i;
  logic              ifu_busy_i;
  logic              lsu_busy_i;
  logic [2:0]        hold_flag_o;
  logic              if_id_flush_o;
  logic              id_ex_flush_o;
  logic              jump_flag_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic [31:0]       stall_cnt_o;
  logic              timeout_o;

  modport master (
    input  ex_jump_req_i, ex_jump_addr_i, id_load_use_i, ifu_busy_i, lsu_busy_i,
    output hold_flag_o, if_id_flush_o, id_ex_flush_o, jump_flag_o, jump_addr_o,
           stall_cnt_o, timeout_o
  );

  modport slave (
    output ex_jump_req_i, ex_jump_addr_i, id_load_use_i, ifu_busy_i, lsu_busy_i,
    input  hold_flag_o, if_id_flush_o, id_ex_flush_o, jump_flag_o, jump_addr_o,
           stall_cnt_o, timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: zero-latency hold/flush/redirect decisions, redirect parking
// behind a busy fetch, stall-cycle statistics and a sticky LSU-wait timeout.
module pipe_ctrl #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_ctrl_if.master  bus
);
  typedef enum logic {RUN, PEND} state_t;

  localparam int                LSU_W    = $clog2(TIMEOUT + 1);
  localparam logic [LSU_W-1:0]  LSU_MAX  = LSU_W'(TIMEOUT);
  localparam logic [LSU_W-1:0]  LSU_LAST = LSU_W'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] pend_addr;
  logic [31:0]       stall_cnt;
  logic [LSU_W-1:0]  lsu_cnt;
  logic              timeout;

  logic [2:0]        hold;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              jump_flag;
  logic [ADDR_W-1:0] jump_addr;

  // Decisions are combinational; an active reset forces every control output low.
  always_comb begin
    hold        = 3'b000;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    jump_flag   = 1'b0;
    jump_addr   = '0;
    if (!rst_n) begin
      if (bus.lsu_busy_i) begin
        hold = 3'b111;
      end else if (state == PEND) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (bus.ifu_busy_i) begin
          hold = 3'b001;
        end else begin
          jump_flag = 1'b1;
          jump_addr = bus.ex_jump_req_i ? bus.ex_jump_addr_i : pend_addr;
        end
      end else if (bus.ex_jump_req_i) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (bus.ifu_busy_i) begin
          hold = 3'b001;
        end else begin
          jump_flag = 1'b1;
          jump_addr = bus.ex_jump_addr_i;
        end
      end else if (bus.id_load_use_i) begin
        hold        = 3'b011;
        id_ex_flush = 1'b1;
      end else if (bus.ifu_busy_i) begin
        hold        = 3'b001;
        if_id_flush = 1'b1;
      end
    end
  end

  // A held LSU freezes the FSM, so a redirect that arrives during the hold is not consumed.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= RUN;
      pend_addr <= '0;
    end else if (!bus.lsu_busy_i) begin
      case (state)
        RUN: begin
          if (bus.ex_jump_req_i && bus.ifu_busy_i) begin
            pend_addr <= bus.ex_jump_addr_i;
            state     <= PEND;
          end
        end
        PEND: begin
          if (bus.ifu_busy_i) begin
            if (bus.ex_jump_req_i) pend_addr <= bus.ex_jump_addr_i;
          end else begin
            pend_addr <= '0;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      stall_cnt <= '0;
      lsu_cnt   <= '0;
      timeout   <= 1'b0;
    end else begin
      if ((hold != 3'b000) && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (bus.lsu_busy_i) begin
        if (lsu_cnt != LSU_MAX) lsu_cnt <= lsu_cnt + 1'b1;
        if (lsu_cnt >= LSU_LAST) timeout <= 1'b1;
      end else begin
        lsu_cnt <= '0;
      end
    end
  end

  assign bus.hold_flag_o   = hold;
  assign bus.if_id_flush_o = if_id_flush;
  assign bus.id_ex_flush_o = id_ex_flush;
  assign bus.jump_flag_o   = jump_flag;
  assign bus.jump_addr_o   = jump_addr;
  assign bus.stall_cnt_o   = stall_cnt;
  assign bus.timeout_o     = timeout;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by randomized traffic,
// each checked against a redirect/stall reference model.
module tb_pipe_ctrl;
  localparam int ADDR_W  = 64;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  pipe_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: one outstanding redirect target (newest wins) plus statistics.
  bit          m_pend;
  logic [63:0] m_target;
  longint      m_stall;
  int          m_run;
  bit          m_to;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_target = '0; m_stall = 0; m_run = 0; m_to = 0;
  endtask

  // One clock: drive inputs after the falling edge, check outputs, then advance the model.
  task automatic cycle(input bit jr, input logic [63:0] ja, input bit lu, input bit ib, input bit lb);
    logic [2:0]  e_hold;
    bit          e_iff, e_ief, e_jf, redirect;
    logic [63:0] e_ja, tgt;
    @(negedge clk);
    bus.ex_jump_req_i  = jr;
    bus.ex_jump_addr_i = ja;
    bus.id_load_use_i  = lu;
    bus.ifu_busy_i     = ib;
    bus.lsu_busy_i     = lb;
    #1;
    e_hold = 3'b000; e_iff = 0; e_ief = 0; e_jf = 0; e_ja = '0;
    redirect = m_pend || jr;
    tgt = jr ? ja : m_target;
    if (lb) e_hold = 3'b111;
    else if (redirect) begin
      e_iff = 1; e_ief = 1;
      if (ib) e_hold = 3'b001;
      else begin e_jf = 1; e_ja = tgt; end
    end else if (lu) begin
      e_hold = 3'b011; e_ief = 1;
    end else if (ib) begin
      e_hold = 3'b001; e_iff = 1;
    end
    check("hold_flag", 64'(bus.hold_flag_o), 64'(e_hold));
    check("if_id_flush", 64'(bus.if_id_flush_o), 64'(e_iff));
    check("id_ex_flush", 64'(bus.id_ex_flush_o), 64'(e_ief));
    check("jump_flag", 64'(bus.jump_flag_o), 64'(e_jf));
    check("jump_addr", bus.jump_addr_o, e_ja);
    check("stall_cnt", 64'(bus.stall_cnt_o), 64'(m_stall));
    check("timeout", 64'(bus.timeout_o), 64'(m_to));
    if (e_hold != 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (lb) begin
      if (m_run < TIMEOUT) m_run++;
      if (m_run >= TIMEOUT) m_to = 1;
    end else begin
      m_run = 0;
      m_pend = redirect && ib;
      if (m_pend) m_target = tgt;
    end
  endtask

  task automatic idle();
    cycle(0, '0, 0, 0, 0);
  endtask

  initial begin
    longint base;
    bus.ex_jump_req_i = 0; bus.ex_jump_addr_i = '0; bus.id_load_use_i = 0;
    bus.ifu_busy_i = 0; bus.lsu_busy_i = 0;
    model_reset();

    // Reset state, with inputs requesting activity while reset is asserted.
    bus.ex_jump_req_i = 1; bus.ex_jump_addr_i = 64'h1234; bus.lsu_busy_i = 1;
    #12;
    check("rst_hold", 64'(bus.hold_flag_o), 64'd0);
    check("rst_jump", 64'(bus.jump_flag_o), 64'd0);
    check("rst_flush", 64'({bus.if_id_flush_o, bus.id_ex_flush_o}), 64'd0);
    check("rst_stall", 64'(bus.stall_cnt_o), 64'd0);
    check("rst_timeout", 64'(bus.timeout_o), 64'd0);
    @(negedge clk);
    bus.ex_jump_req_i = 0; bus.lsu_busy_i = 0;
    rst_n = 0;

    // Immediate redirect.
    cycle(1, 64'h8000_0100, 0, 0, 0);
    check("jump_now_addr", bus.jump_addr_o, 64'h8000_0100);
    idle();

    // Redirect parked behind a 3-cycle busy fetch.
    cycle(1, 64'h8000_0200, 0, 1, 0);
    cycle(0, '0, 0, 1, 0);
    cycle(0, '0, 0, 1, 0);
    cycle(0, '0, 0, 0, 0);
    check("pend_release_addr", bus.jump_addr_o, 64'h8000_0200);
    idle();

    // LSU hold dominates jump and load-use; the jump is taken once the LSU hold drops.
    cycle(1, 64'h8000_0300, 1, 0, 1);
    check("lsu_hold", 64'(bus.hold_flag_o), 64'd7);
    cycle(1, 64'h8000_0300, 1, 0, 1);
    cycle(1, 64'h8000_0300, 1, 0, 0);
    check("lsu_then_jump", 64'(bus.jump_flag_o), 64'd1);
    idle();

    // Single load-use bubble.
    base = m_stall;
    cycle(0, '0, 1, 0, 0);
    check("load_use_hold", 64'(bus.hold_flag_o), 64'd3);
    idle();
    check("load_use_stall", 64'(bus.stall_cnt_o), 64'(base + 1));

    // LSU timeout after TIMEOUT consecutive busy cycles, sticky afterwards.
    base = m_stall;
    repeat (3) cycle(0, '0, 0, 0, 1);
    check("timeout_early", 64'(bus.timeout_o), 64'd0);
    cycle(0, '0, 0, 0, 1);
    idle();
    check("timeout_set", 64'(bus.timeout_o), 64'd1);
    check("timeout_stall", 64'(bus.stall_cnt_o), 64'(base + 4));
    idle();

    // Reset in the middle of a pending redirect.
    cycle(1, 64'h8000_0400, 0, 1, 0);
    @(negedge clk);
    bus.ex_jump_req_i = 0; bus.ifu_busy_i = 1;
    rst_n = 1;
    #1;
    check("midrst_hold", 64'(bus.hold_flag_o), 64'd0);
    check("midrst_flush", 64'({bus.if_id_flush_o, bus.id_ex_flush_o}), 64'd0);
    check("midrst_stall", 64'(bus.stall_cnt_o), 64'd0);
    check("midrst_timeout", 64'(bus.timeout_o), 64'd0);
    model_reset();
    @(negedge clk);
    bus.ifu_busy_i = 0;
    rst_n = 0;
    idle();
    check("after_rst_jump", 64'(bus.jump_flag_o), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) == 0), {$urandom(), $urandom()},
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning width of PC/jump address.
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning LSU-wait cycles before timeout flag.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port ex_jump_req_i, input, 1, EX stage requests redirect (branch taken/jump/trap).
REQ-006 SHALL have port ex_jump_addr_i, input, ADDR_W, redirect target.
REQ-007 SHALL have port id_load_use_i, input, 1, ID instruction depends on load in EX.
REQ-008 SHALL have port ifu_busy_i, input, 1, fetch not yet returned valid instruction.
REQ-009 SHALL have port lsu_busy_i, input, 1, memory access outstanding.
REQ-010 SHALL have port hold_flag_o, output, 3, hold bits: [0] PC, [1] IF_ID, [2] ID_EX.
REQ-011 SHALL have port if_id_flush_o, output, 1, IF_ID loads NOP/zero PC this cycle.
REQ-012 SHALL have port id_ex_flush_o, output, 1, ID_EX loads bubble this cycle.
REQ-013 SHALL have port jump_flag_o, output, 1, PC loads jump_addr_o this cycle.
REQ-014 SHALL have port jump_addr_o, output, ADDR_W, redirect target to PC.
REQ-015 SHALL have port stall_cnt_o, output, 32, count of cycles with any hold bit set.
REQ-016 SHALL have port timeout_o, output, 1, sticky LSU timeout flag.

Function
REQ-017 SHALL implement FSM states RUN and PEND (redirect pending behind busy fetch).
REQ-018 SHALL make hold/flush/jump outputs combinational from current state and inputs (zero latency).
REQ-019 SHALL apply priority in RUN: lsu_busy > ex_jump_req > id_load_use > ifu_busy > none.
REQ-020 SHALL, when lsu_busy_i=1 (any state), drive hold_flag_o=3'b111, no flush, jump_flag_o=0, state unchanged; jump request is not consumed.
REQ-021 SHALL, in RUN with jump and ifu_busy_i=0, drive jump_flag_o=1, jump_addr_o=ex_jump_addr_i, if_id_flush_o=1, id_ex_flush_o=1, hold_flag_o=0; stay RUN.
REQ-022 SHALL, in RUN with jump and ifu_busy_i=1, latch ex_jump_addr_i into pend_addr, drive if_id_flush_o=1, id_ex_flush_o=1, hold_flag_o=3'b001, jump_flag_o=0; next state PEND.
REQ-023 SHALL, on load-use (no jump), drive hold_flag_o=3'b011, id_ex_flush_o=1, if_id_flush_o=0.
REQ-024 SHALL, on ifu_busy only, drive hold_flag_o=3'b001, if_id_flush_o=1.
REQ-025 SHALL, in PEND with ifu_busy_i=1, drive hold_flag_o=3'b001, if_id_flush_o=1, id_ex_flush_o=1; remain PEND.
REQ-026 SHALL, in PEND with ifu_busy_i=0, drive jump_flag_o=1, jump_addr_o=pend_addr, if_id_flush_o=1, id_ex_flush_o=1; next state RUN.
REQ-027 SHALL, on ex_jump_req_i in PEND, overwrite pend_addr with newest ex_jump_addr_i; id_load_use_i ignored in PEND.
REQ-028 SHALL drive jump_addr_o=0 whenever jump_flag_o=0.
REQ-029 SHALL increment stall_cnt_o each cycle hold_flag_o!=0, saturating at 32'hFFFF_FFFF.
REQ-030 SHALL count consecutive lsu_busy_i cycles (cleared when low); set timeout_o when count reaches TIMEOUT, sticky until reset; counter saturates.

Reset
REQ-031 SHALL, while rst_n=1, force state RUN, pend_addr=0, stall_cnt_o=0, lsu wait count=0, timeout_o=0, and all hold/flush/jump outputs 0, asynchronously.
REQ-032 SHALL discard any pending redirect on reset mid-PEND; first cycle after release is RUN.

Verification
REQ-033 SHALL verify: RUN, ex_jump_req=1, addr=0x8000_0100, ifu_busy=0 -> same cycle jump_flag=1, jump_addr=0x8000_0100, both flushes=1, hold=000.
REQ-034 SHALL verify: jump addr 0x8000_0200 with ifu_busy=1 for 3 cycles -> 3 cycles hold=001+flushes, then jump_flag=1, jump_addr=0x8000_0200 on cycle ifu_busy falls.
REQ-035 SHALL verify: lsu_busy=1 together with jump and load-use -> hold=111, no flush/jump; jump taken cycle after lsu_busy drops.
REQ-036 SHALL verify: id_load_use=1 one cycle -> hold=011, id_ex_flush=1; stall_cnt increments by 1.
REQ-037 SHALL verify: TIMEOUT=4, lsu_busy high 4 cycles -> timeout_o=1 after 4th edge, stays 1 after lsu_busy low; stall_cnt=4.
REQ-038 SHALL verify: assert rst_n mid-PEND -> outputs 0 immediately, no jump_flag after release.
